// File: rtl/ripemd160_pkg.sv
// RIPEMD-160 shared definitions: IV, round constants, message/rotate tables,
// boolean round functions and byte swap. Used by the multi-block core and its
// step sub-module (optional input byte swap: RIPEMD160_BSWAP_EN, in the core).
package ripemd160_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFinal} rmd_state_e;

  // One line's working state; also used for the chaining value (a = h0 ... e = h4).
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } rmd_words_t;

  localparam rmd_words_t IV = '{
    a: 32'h67452301, b: 32'hEFCDAB89, c: 32'h98BADCFE, d: 32'h10325476, e: 32'hC3D2E1F0
  };

  localparam logic [31:0] K_L [5] = '{
    32'h00000000, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hA953FD4E
  };
  localparam logic [31:0] K_R [5] = '{
    32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9, 32'h00000000
  };

  localparam logic [3:0] R_L [80] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
    7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
    3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
    1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
    4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13
  };
  localparam logic [3:0] R_R [80] = '{
    5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
    6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
    15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
    8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
    12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11
  };
  localparam logic [3:0] S_L [80] = '{
    11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
    7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
    11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
    11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
    9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6
  };
  localparam logic [3:0] S_R [80] = '{
    8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
    9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
    9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
    15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
    8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11
  };

  // Boolean function of a 16-step round (0..4).
  function automatic logic [31:0] rmd_f(input logic [2:0] rnd, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] z);
    logic [31:0] res;
    case (rnd)
      3'd0:    res = x ^ y ^ z;
      3'd1:    res = (x & y) | (~x & z);
      3'd2:    res = (x | ~y) ^ z;
      3'd3:    res = (x & z) | (y & ~z);
      default: res = x ^ (y | ~z);
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [3:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/ripemd160_step.sv
// One RIPEMD-160 step on both the left and right lines; purely combinational.
module ripemd160_step
  import ripemd160_pkg::*;
(
  input  logic [6:0]  j_i,
  input  rmd_words_t  l_i,
  input  rmd_words_t  r_i,
  input  logic [31:0] xl_i,
  input  logic [31:0] xr_i,
  output rmd_words_t  l_o,
  output rmd_words_t  r_o
);

  logic [2:0]  rnd;
  logic [2:0]  rnd_r;
  logic [31:0] tl;
  logic [31:0] tr;

  // Right line walks the boolean functions in reverse round order.
  always_comb begin
    rnd   = j_i[6:4];
    rnd_r = 3'd4 - rnd;
    tl = rol32(l_i.a + rmd_f(rnd, l_i.b, l_i.c, l_i.d) + xl_i + K_L[rnd], S_L[j_i]) + l_i.e;
    tr = rol32(r_i.a + rmd_f(rnd_r, r_i.b, r_i.c, r_i.d) + xr_i + K_R[rnd], S_R[j_i]) + r_i.e;
    l_o = '{a: l_i.e, b: tl, c: l_i.b, d: rol32(l_i.c, 4'd10), e: l_i.d};
    r_o = '{a: r_i.e, b: tr, c: r_i.b, d: rol32(r_i.c, 4'd10), e: r_i.d};
  end

endmodule

// File: rtl/ripemd160_mb_core.sv
// Multi-block RIPEMD-160 compression engine with chained state across blocks,
// STEPS_PER_CYCLE steps per clock and a ready/valid block input.
// Define RIPEMD160_BSWAP_EN to take the block as a big-endian byte stream.
module ripemd160_mb_core
  import ripemd160_pkg::*;
#(
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic         i_first,
  input  logic         i_last,
  input  logic [511:0] block,
  output logic         busy,
  output logic         o_valid,
  output logic [159:0] ans
);

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
        STEPS_PER_CYCLE == 8 || STEPS_PER_CYCLE == 16)) begin : gen_steps_check
    $error("STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [6:0] StepInc = 7'(STEPS_PER_CYCLE);

  rmd_state_e   state_q;
  logic [6:0]   j_q;
  logic [6:0]   j_next;
  logic [31:0]  x_q [16];
  logic [31:0]  blk_w [16];
  logic         last_q;
  rmd_words_t   h_q, wl_q, wr_q;
  rmd_words_t   h_new;
  rmd_words_t   run_l, run_r;
  logic [159:0] digest;
  logic [159:0] ans_q;
  logic         o_valid_q;

  // Split the input block into message words, optionally byte swapping each.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
`ifdef RIPEMD160_BSWAP_EN
      blk_w[i] = bswap32(block[511-32*i -: 32]);
`else
      blk_w[i] = block[32*i +: 32];
`endif
    end
  end

  // Combinational chain of steps j_q .. j_q+STEPS_PER_CYCLE-1.
  for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : gen_step
    logic [6:0] jk;
    rmd_words_t in_l, in_r, out_l, out_r;
    assign jk = j_q + 7'(k);
    if (k == 0) begin : gen_head
      assign in_l = wl_q;
      assign in_r = wr_q;
    end else begin : gen_link
      assign in_l = gen_step[k-1].out_l;
      assign in_r = gen_step[k-1].out_r;
    end
    ripemd160_step u_step (
      .j_i  (jk),
      .l_i  (in_l),
      .r_i  (in_r),
      .xl_i (x_q[R_L[jk]]),
      .xr_i (x_q[R_R[jk]]),
      .l_o  (out_l),
      .r_o  (out_r)
    );
  end

  assign run_l  = gen_step[STEPS_PER_CYCLE-1].out_l;
  assign run_r  = gen_step[STEPS_PER_CYCLE-1].out_r;
  assign j_next = j_q + StepInc;

  // Merge both lines into the chaining value and form the byte-ordered digest.
  always_comb begin
    h_new.a = h_q.b + wl_q.c + wr_q.d;
    h_new.b = h_q.c + wl_q.d + wr_q.e;
    h_new.c = h_q.d + wl_q.e + wr_q.a;
    h_new.d = h_q.e + wl_q.a + wr_q.b;
    h_new.e = h_q.a + wl_q.b + wr_q.c;
    digest  = {bswap32(h_new.a), bswap32(h_new.b), bswap32(h_new.c),
               bswap32(h_new.d), bswap32(h_new.e)};
  end

  // Control FSM with all datapath registers and registered digest outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      j_q       <= '0;
      last_q    <= 1'b0;
      h_q       <= IV;
      wl_q      <= '0;
      wr_q      <= '0;
      ans_q     <= '0;
      o_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) x_q[i] <= '0;
    end else begin
      o_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            for (int i = 0; i < 16; i++) x_q[i] <= blk_w[i];
            last_q <= i_last;
            if (i_first) begin
              h_q  <= IV;
              wl_q <= IV;
              wr_q <= IV;
            end else begin
              wl_q <= h_q;
              wr_q <= h_q;
            end
            j_q     <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          wl_q <= run_l;
          wr_q <= run_r;
          if (j_next == 7'd80) begin
            // Park the counter at 0 so table lookups stay in range outside RUN.
            j_q     <= '0;
            state_q <= StFinal;
          end else begin
            j_q <= j_next;
          end
        end
        StFinal: begin
          h_q <= h_new;
          if (last_q) begin
            ans_q     <= digest;
            o_valid_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign i_ready = (state_q == StIdle);
  assign busy    = (state_q != StIdle);
  assign o_valid = o_valid_q;
  assign ans     = ans_q;

endmodule

// File: tb/tb_ripemd160_mb_core.sv
// Scoreboard bench for ripemd160_mb_core: known-answer vectors, chaining,
// back-to-back handshake, mid-run reset and random messages against a
// loop-based RIPEMD-160 model; extra instances at 4 and 16 steps per cycle.
module tb_ripemd160_mb_core;

  localparam int unsigned SPC = 1;
  localparam int unsigned LAT = 80 / SPC + 1;

  localparam logic [159:0] KAT_EMPTY = 160'h9c1185a5c5e9fc54612808977ee8f548b2258d31;
  localparam logic [159:0] KAT_ABC   = 160'h8eb208f7e05d987a9b044a8e98c6b087f15a0bfc;
  localparam logic [159:0] KAT_TWO   = 160'h9b752e45573d4b39f4dbd3323cab82bf63326bfb;

  localparam logic [4:0][31:0] TB_IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                        32'hEFCDAB89, 32'h67452301};

  localparam logic [31:0] TK  [5] = '{32'h0, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC,
                                      32'hA953FD4E};
  localparam logic [31:0] TKP [5] = '{32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9,
                                      32'h0};
  localparam int TR [80] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
    7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
    3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
    1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
    4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13};
  localparam int TRP [80] = '{
    5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
    6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
    15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
    8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
    12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11};
  localparam int TS [80] = '{
    11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
    7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
    11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
    11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
    9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6};
  localparam int TSP [80] = '{
    8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
    9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
    9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
    15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
    8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid, i_ready, i_first, i_last, busy, o_valid;
  logic [511:0] block;
  logic [159:0] ans;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [159:0] dig;
    int unsigned  tacc;
  } exp_t;
  exp_t sb[$];
  logic [4:0][31:0] h_model;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ripemd160_mb_core #(.STEPS_PER_CYCLE(SPC)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_first(i_first),
    .i_last(i_last), .block(block), .busy(busy), .o_valid(o_valid), .ans(ans)
  );

  function automatic logic [31:0] tb_rol(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] tb_f(input int j, input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
    if (j < 16) return x ^ y ^ z;
    else if (j < 32) return (x & y) | (~x & z);
    else if (j < 48) return (x | ~y) ^ z;
    else if (j < 64) return (x & z) | (y & ~z);
    else return x ^ (y | ~z);
  endfunction

  function automatic logic [31:0] tb_bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [4:0][31:0] ref_compress(input logic [4:0][31:0] h,
                                                     input logic [15:0][31:0] x);
    logic [31:0] al, bl, cl, dl, el, ar, br, cr, dr, er, t;
    logic [4:0][31:0] o;
    al = h[0]; bl = h[1]; cl = h[2]; dl = h[3]; el = h[4];
    ar = h[0]; br = h[1]; cr = h[2]; dr = h[3]; er = h[4];
    for (int j = 0; j < 80; j++) begin
      t  = tb_rol(al + tb_f(j, bl, cl, dl) + x[TR[j]] + TK[j/16], TS[j]) + el;
      al = el; el = dl; dl = tb_rol(cl, 10); cl = bl; bl = t;
      t  = tb_rol(ar + tb_f(79 - j, br, cr, dr) + x[TRP[j]] + TKP[j/16], TSP[j]) + er;
      ar = er; er = dr; dr = tb_rol(cr, 10); cr = br; br = t;
    end
    o[0] = h[1] + cl + dr;
    o[1] = h[2] + dl + er;
    o[2] = h[3] + el + ar;
    o[3] = h[4] + al + br;
    o[4] = h[0] + bl + cr;
    return o;
  endfunction

  function automatic logic [159:0] to_digest(input logic [4:0][31:0] h);
    logic [159:0] d;
    for (int i = 0; i < 5; i++) d[159-32*i -: 32] = tb_bswap(h[i]);
    return d;
  endfunction

  function automatic logic [511:0] pack_block(input logic [15:0][31:0] w);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) begin
`ifdef RIPEMD160_BSWAP_EN
      b[511-32*i -: 32] = tb_bswap(w[i]);
`else
      b[32*i +: 32] = w[i];
`endif
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer a block (i_valid stays high on return) and update the model on acceptance.
  task automatic send(input logic [15:0][31:0] w, input bit first, input bit last,
                      input bit expect_out, input bit use_kat, input logic [159:0] kat,
                      output int unsigned t_acc);
    bit ok;
    ok = 1'b0;
    t_acc = 0;
    @(negedge clk);
    block = pack_block(w);
    i_first = first;
    i_last = last;
    i_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (i_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: i_ready=0, expected 1");
      return;
    end
    @(posedge clk);
    t_acc = cyc;
    if (first) h_model = TB_IV;
    h_model = ref_compress(h_model, w);
    if (last && expect_out) sb.push_back('{dig: use_kat ? kat : to_digest(h_model), tacc: t_acc});
    #1;
    check("busy_after_accept", 160'(busy), 160'(1));
    check("ready_after_accept", 160'(i_ready), 160'(0));
  endtask

  task automatic drop_valid();
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL drain_timeout: %0d digests outstanding, expected 0", sb.size());
    sb.delete();
  endtask

  // Monitor: every o_valid pulse must match the oldest expected digest and latency.
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_o_valid: o_valid=1 with ans=%0h, expected 0", ans);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("digest", ans, e.dig);
        check("latency", 160'(cyc - e.tacc - 1), 160'(LAT));
      end
    end
  end

  // Additional instances at 4 and 16 steps per cycle: digest and latency only.
  for (genvar g = 0; g < 2; g++) begin : gen_aux
    localparam int unsigned AS = (g == 0) ? 4 : 16;
    logic         a_rst_n, a_valid, a_ready, a_busy, a_ovalid;
    logic [511:0] a_block;
    logic [159:0] a_ans;
    bit           done = 1'b0;

    ripemd160_mb_core #(.STEPS_PER_CYCLE(AS)) u_dut (
      .clk(clk), .rst_n(a_rst_n), .i_valid(a_valid), .i_ready(a_ready), .i_first(1'b1),
      .i_last(1'b1), .block(a_block), .busy(a_busy), .o_valid(a_ovalid), .ans(a_ans)
    );

    initial begin
      logic [15:0][31:0] aw;
      logic [159:0]      aexp;
      int unsigned       at;
      bit                got;
      a_rst_n = 1'b0;
      a_valid = 1'b0;
      a_block = '0;
      repeat (3) @(negedge clk);
      a_rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
        aw = '0;
        if (n == 0) begin
          aw[0] = 32'h80636261;
          aw[14] = 32'h00000018;
          aexp = KAT_ABC;
        end else begin
          for (int i = 0; i < 16; i++) aw[i] = $urandom;
          aexp = to_digest(ref_compress(TB_IV, aw));
        end
        @(negedge clk);
        a_block = pack_block(aw);
        a_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
          if (a_ready) begin
            got = 1'b1;
            break;
          end
          @(negedge clk);
        end
        if (!got) begin
          tests_run++;
          tests_failed++;
          $display("FAIL aux%0d_accept_timeout: i_ready=0, expected 1", AS);
        end else begin
          @(posedge clk);
          at = cyc;
          @(negedge clk);
          a_valid = 1'b0;
          got = 1'b0;
          for (int c = 0; c < 50; c++) begin
            if (a_ovalid) begin
              got = 1'b1;
              break;
            end
            @(negedge clk);
          end
          if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL aux%0d_no_o_valid: o_valid=0, expected 1", AS);
          end else begin
            check($sformatf("aux%0d_digest", AS), a_ans, aexp);
            check($sformatf("aux%0d_latency", AS), 160'(cyc - at - 1), 160'(80 / AS + 1));
          end
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    logic [15:0][31:0] w_empty, w_abc, w_b1, w_b2, w;
    logic [7:0]        msg [128];
    int unsigned       t1, t2;
    int                nb, gap;
    bit                fst;

    w_empty = '0;
    w_empty[0] = 32'h00000080;
    w_abc = '0;
    w_abc[0] = 32'h80636261;
    w_abc[14] = 32'h00000018;
    for (int i = 0; i < 128; i++) msg[i] = 8'h00;
    for (int i = 0; i < 80; i++) msg[i] = 8'h30 + 8'((i + 1) % 10);
    msg[80] = 8'h80;
    msg[120] = 8'h80;
    msg[121] = 8'h02;
    for (int i = 0; i < 16; i++) begin
      w_b1[i] = {msg[4*i+3], msg[4*i+2], msg[4*i+1], msg[4*i]};
      w_b2[i] = {msg[64+4*i+3], msg[64+4*i+2], msg[64+4*i+1], msg[64+4*i]};
    end

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last = 1'b0;
    block = '0;
    h_model = TB_IV;
    repeat (3) @(negedge clk);
    check("reset_i_ready", 160'(i_ready), 160'(1));
    check("reset_busy", 160'(busy), 160'(0));
    check("reset_o_valid", 160'(o_valid), 160'(0));
    check("reset_ans", ans, 160'(0));
    rst_n = 1'b1;

    // Single-block known answers.
    send(w_empty, 1'b1, 1'b1, 1'b1, 1'b1, KAT_EMPTY, t1);
    drop_valid();
    wait_drain();
    send(w_abc, 1'b1, 1'b1, 1'b1, 1'b1, KAT_ABC, t1);
    drop_valid();
    wait_drain();

    // Two-block message; no digest may appear after the first block.
    send(w_b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, t1);
    drop_valid();
    repeat (3) @(negedge clk);
    send(w_b2, 1'b0, 1'b1, 1'b1, 1'b1, KAT_TWO, t1);
    drop_valid();
    wait_drain();

    // Back-to-back with i_valid held through the busy period.
    send(w_empty, 1'b1, 1'b1, 1'b1, 1'b1, KAT_EMPTY, t1);
    send(w_abc, 1'b1, 1'b1, 1'b1, 1'b1, KAT_ABC, t2);
    check("b2b_gap", 160'(t2 - t1), 160'(80 / SPC + 2));
    drop_valid();
    wait_drain();

    // Reset in the middle of a run, then an unflagged block chains from IV.
    send(w_abc, 1'b1, 1'b1, 1'b0, 1'b0, '0, t1);
    drop_valid();
    repeat ((80 / SPC) / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_o_valid", 160'(o_valid), 160'(0));
    check("midrst_ans", ans, 160'(0));
    check("midrst_i_ready", 160'(i_ready), 160'(1));
    check("midrst_busy", 160'(busy), 160'(0));
    h_model = TB_IV;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(w_empty, 1'b0, 1'b1, 1'b1, 1'b1, KAT_EMPTY, t1);
    drop_valid();
    wait_drain();

    // Random messages of 1..3 blocks, occasionally continuing the previous chain.
    for (int m = 0; m < 12; m++) begin
      nb = $urandom_range(1, 3);
      fst = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) w[i] = $urandom;
        send(w, (b == 0) && fst, b == nb - 1, 1'b1, 1'b0, '0, t1);
        gap = $urandom_range(0, 2);
        if (gap != 0) begin
          drop_valid();
          repeat (gap) @(negedge clk);
        end
      end
    end
    drop_valid();
    wait_drain();

    for (int n = 0; n < 2000; n++) begin
      if (gen_aux[0].done && gen_aux[1].done) break;
      @(negedge clk);
    end
    if (!(gen_aux[0].done && gen_aux[1].done)) begin
      tests_run++;
      tests_failed++;
      $display("FAIL aux_timeout: done=%0b%0b, expected 11", gen_aux[0].done, gen_aux[1].done);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
